axi_slave_ram: RTL and testbench

AXI4 memory slave (responder): an internal word-addressed RAM behind full AXI4 write and read channels. It is the far end for the team's AXI4 burst-traffic master and stands in for the DDR controller in simulation and on-chip loopback tests. Write and read channels run independently, with one outstanding transaction per direction.

---
 rtl/axi_slave_ram.sv | 214 +++++++++++++++++++++
 tb/tb_axi_slave_ram.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_ram.sv
// AXI4 memory slave: word-addressed RAM behind independent write
// and read burst engines, one outstanding transaction per direction.
module axi_slave_ram #(
  parameter int AXI_DW = 32,
  parameter int AXI_AW = 32,
  parameter logic [AXI_AW-1:0] BASE_ADDR = 'h0010_0000,
  parameter int MEM_DEPTH = 1024
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [7:0]          s_axi_awid,
  input  logic [AXI_AW-1:0]   s_axi_awaddr,
  input  logic [7:0]          s_axi_awlen,
  input  logic [2:0]          s_axi_awsize,
  input  logic [1:0]          s_axi_awburst,
  input  logic                s_axi_awlock,
  input  logic [3:0]          s_axi_awcache,
  input  logic [2:0]          s_axi_awprot,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [AXI_DW-1:0]   s_axi_wdata,
  input  logic [AXI_DW/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [7:0]          s_axi_bid,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [7:0]          s_axi_arid,
  input  logic [AXI_AW-1:0]   s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic [2:0]          s_axi_arsize,
  input  logic [1:0]          s_axi_arburst,
  input  logic                s_axi_arlock,
  input  logic [3:0]          s_axi_arcache,
  input  logic [2:0]          s_axi_arprot,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [7:0]          s_axi_rid,
  output logic [AXI_DW-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready
);
  localparam int NB = AXI_DW / 8;
  localparam int LSB = $clog2(NB);
  localparam int IW = $clog2(MEM_DEPTH);
  localparam logic [AXI_AW-1:0] SPAN = AXI_AW'(MEM_DEPTH * NB);
  localparam logic [AXI_AW-1:0] STEP = AXI_AW'(NB);
  localparam logic [2:0] SIZE = 3'(LSB);
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  logic [AXI_DW-1:0] mem [MEM_DEPTH];

  function automatic logic in_range(input logic [AXI_AW-1:0] a);
    return (a >= BASE_ADDR) && ((a - BASE_ADDR) < SPAN);
  endfunction

  function automatic logic [IW-1:0] widx(input logic [AXI_AW-1:0] a);
    return IW'((a - BASE_ADDR) >> LSB);
  endfunction

  logic unused_sig;
  assign unused_sig = ^{s_axi_awburst, s_axi_awlock, s_axi_awcache,
                        s_axi_awprot, s_axi_arburst, s_axi_arlock,
                        s_axi_arcache, s_axi_arprot};

  wstate_t           wstate;
  logic [AXI_AW-1:0] waddr;
  logic [7:0]        wlen;
  logic [7:0]        wcnt;
  logic [7:0]        wid;
  logic              werr;
  logic              w_fire;
  logic              w_last;
  logic              w_in;
  logic              w_bad;

  assign w_fire = s_axi_wvalid && s_axi_wready;
  assign w_last = (wcnt == wlen);
  assign w_in   = in_range(waddr);
  assign w_bad  = !w_in || (s_axi_wlast != w_last);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wstate        <= W_IDLE;
      s_axi_awready <= 1'b1;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bid     <= '0;
      s_axi_bresp   <= OKAY;
      waddr         <= '0;
      wlen          <= '0;
      wcnt          <= '0;
      wid           <= '0;
      werr          <= 1'b0;
    end else begin
      unique case (wstate)
        W_IDLE: if (s_axi_awvalid) begin
          wid           <= s_axi_awid;
          waddr         <= s_axi_awaddr;
          wlen          <= s_axi_awlen;
          wcnt          <= '0;
          werr          <= (s_axi_awsize != SIZE);
          s_axi_awready <= 1'b0;
          s_axi_wready  <= 1'b1;
          wstate        <= W_DATA;
        end
        W_DATA: if (s_axi_wvalid) begin
          if (w_last) begin
            s_axi_wready <= 1'b0;
            s_axi_bvalid <= 1'b1;
            s_axi_bid    <= wid;
            s_axi_bresp  <= (werr || w_bad) ? SLVERR : OKAY;
            wstate       <= W_RESP;
          end else begin
            waddr <= waddr + STEP;
            wcnt  <= wcnt + 8'd1;
            werr  <= werr || w_bad;
          end
        end
        W_RESP: if (s_axi_bready) begin
          s_axi_bvalid  <= 1'b0;
          s_axi_awready <= 1'b1;
          wstate        <= W_IDLE;
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // RAM holds its contents across reset
  always_ff @(posedge clk) begin
    if (w_fire && w_in) begin
      for (int b = 0; b < NB; b++) begin
        if (s_axi_wstrb[b])
          mem[widx(waddr)][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  rstate_t           rstate;
  logic [AXI_AW-1:0] raddr;
  logic [7:0]        rlen;
  logic [7:0]        rcnt;
  logic              rserr;
  logic [AXI_AW-1:0] ld_addr;
  logic              ld_in;
  logic [AXI_DW-1:0] ld_data;
  logic              ld_err;

  always_comb begin
    ld_addr = (rstate == R_IDLE) ? s_axi_araddr : raddr;
    ld_in   = in_range(ld_addr);
    ld_data = ld_in ? mem[widx(ld_addr)] : '0;
    ld_err  = !ld_in;
    if (rstate == R_IDLE) ld_err = ld_err || (s_axi_arsize != SIZE);
    else                  ld_err = ld_err || rserr;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rstate        <= R_IDLE;
      s_axi_arready <= 1'b1;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rid     <= '0;
      s_axi_rresp   <= OKAY;
      s_axi_rdata   <= '0;
      raddr         <= '0;
      rlen          <= '0;
      rcnt          <= '0;
      rserr         <= 1'b0;
    end else begin
      unique case (rstate)
        R_IDLE: if (s_axi_arvalid) begin
          s_axi_rid     <= s_axi_arid;
          s_axi_rdata   <= ld_data;
          s_axi_rresp   <= ld_err ? SLVERR : OKAY;
          s_axi_rlast   <= (s_axi_arlen == 8'd0);
          s_axi_rvalid  <= 1'b1;
          s_axi_arready <= 1'b0;
          raddr         <= s_axi_araddr + STEP;
          rlen          <= s_axi_arlen;
          rcnt          <= '0;
          rserr         <= (s_axi_arsize != SIZE);
          rstate        <= R_DATA;
        end
        R_DATA: if (s_axi_rready) begin
          if (s_axi_rlast) begin
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_arready <= 1'b1;
            rstate        <= R_IDLE;
          end else begin
            s_axi_rdata <= ld_data;
            s_axi_rresp <= ld_err ? SLVERR : OKAY;
            s_axi_rlast <= (rcnt + 8'd1 == rlen);
            raddr       <= raddr + STEP;
            rcnt        <= rcnt + 8'd1;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slave_ram.sv
// Directed bench for axi_slave_ram: bursts, strobes, stalls,
// out-of-range beats, wlast errors and mid-burst reset.
module tb_axi_slave_ram;
  localparam logic [31:0] BASE = 32'h0010_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic [7:0]  awid, awlen, arid, arlen;
  logic [31:0] awaddr, araddr, wdata;
  logic [2:0]  awsize, arsize, awprot, arprot;
  logic [1:0]  awburst, arburst;
  logic        awlock, arlock;
  logic [3:0]  awcache, arcache, wstrb;
  logic        awvalid, awready, wlast, wvalid, wready;
  logic [7:0]  bid, rid;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready, arvalid, arready;
  logic [31:0] rdata;
  logic        rlast, rvalid, rready;

  int errors = 0;
  int checks = 0;

  axi_slave_ram dut (
    .clk(clk), .rstn(rstn),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
    .s_axi_awsize(awsize), .s_axi_awburst(awburst),
    .s_axi_awlock(awlock), .s_axi_awcache(awcache),
    .s_axi_awprot(awprot), .s_axi_awvalid(awvalid),
    .s_axi_awready(awready), .s_axi_wdata(wdata),
    .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
    .s_axi_bready(bready), .s_axi_arid(arid),
    .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_arsize(arsize), .s_axi_arburst(arburst),
    .s_axi_arlock(arlock), .s_axi_arcache(arcache),
    .s_axi_arprot(arprot), .s_axi_arvalid(arvalid),
    .s_axi_arready(arready), .s_axi_rid(rid), .s_axi_rdata(rdata),
    .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  function automatic logic [31:0] wa(input int w);
    return BASE + 32'(w * 4);
  endfunction

  task automatic wr_burst(input logic [7:0] id, input logic [31:0] a,
                          input logic [7:0] len, input logic [31:0] d0,
                          input logic [3:0] strb, input int early,
                          input int bdelay, input logic [1:0] eresp,
                          input string nm);
    int n;
    n = 0;
    awid = id; awaddr = a; awlen = len; awsize = 3'd2;
    awburst = 2'b01; awvalid = 1'b1;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (awready !== 1'b1) begin
      errors++;
      $display("FAIL %s aw_timeout: awready=%b required 1", nm, awready);
    end
    @(negedge clk);
    awvalid = 1'b0;
    checks++;
    if ({awready, wready} !== 2'b01) begin
      errors++;
      $display("FAIL %s aw_accept: awready=%b wready=%b required 0 1",
               nm, awready, wready);
    end
    for (int i = 0; i <= int'(len); i++) begin
      int m;
      m = 0;
      wvalid = 1'b1; wdata = d0 + 32'(i); wstrb = strb;
      wlast = (early >= 0) ? (i == early) : (i == int'(len));
      while (!wready && m < 50) begin @(negedge clk); m++; end
      checks++;
      if (wready !== 1'b1) begin
        errors++;
        $display("FAIL %s w_timeout beat %0d: wready=%b required 1",
                 nm, i, wready);
      end
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    checks++;
    if ({bvalid, wready, bid, bresp} !== {1'b1, 1'b0, id, eresp}) begin
      errors++;
      $display("FAIL %s b_first: bvalid=%b wready=%b bid=%h bresp=%b required 1 0 %h %b",
               nm, bvalid, wready, bid, bresp, id, eresp);
    end
    for (int k = 0; k < bdelay; k++) begin
      @(negedge clk);
      checks++;
      if ({bvalid, bresp, awready} !== {1'b1, eresp, 1'b0}) begin
        errors++;
        $display("FAIL %s b_hold cycle %0d: bvalid=%b bresp=%b awready=%b required 1 %b 0",
                 nm, k, bvalid, bresp, awready, eresp);
      end
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    checks++;
    if ({bvalid, awready} !== 2'b01) begin
      errors++;
      $display("FAIL %s b_done: bvalid=%b awready=%b required 0 1",
               nm, bvalid, awready);
    end
  endtask

  // first nok beats carry d0+i / OKAY, the rest 0 / SLVERR
  task automatic rd_burst(input logic [7:0] id, input logic [31:0] a,
                          input logic [7:0] len, input logic [31:0] d0,
                          input int nok, input bit stall,
                          input string nm);
    int n;
    n = 0;
    arid = id; araddr = a; arlen = len; arsize = 3'd2;
    arburst = 2'b01; arvalid = 1'b1;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (arready !== 1'b1) begin
      errors++;
      $display("FAIL %s ar_timeout: arready=%b required 1", nm, arready);
    end
    @(negedge clk);
    arvalid = 1'b0;
    checks++;
    if ({rvalid, arready} !== 2'b10) begin
      errors++;
      $display("FAIL %s ar_accept: rvalid=%b arready=%b required 1 0",
               nm, rvalid, arready);
    end
    for (int i = 0; i <= int'(len); i++) begin
      logic [31:0] ed;
      logic [1:0]  er;
      logic        el;
      ed = (i < nok) ? d0 + 32'(i) : 32'h0;
      er = (i < nok) ? 2'b00 : 2'b10;
      el = (i == int'(len));
      checks++;
      if ({rvalid, rid, rdata, rresp, rlast} !== {1'b1, id, ed, er, el}) begin
        errors++;
        $display("FAIL %s r_beat %0d: rvalid=%b rid=%h rdata=%h rresp=%b rlast=%b required 1 %h %h %b %b",
                 nm, i, rvalid, rid, rdata, rresp, rlast, id, ed, er, el);
      end
      if (stall && i > 0) begin
        rready = 1'b0;
        repeat (2) begin
          @(negedge clk);
          checks++;
          if ({rvalid, rdata, rresp, rlast} !== {1'b1, ed, er, el}) begin
            errors++;
            $display("FAIL %s r_stall %0d: rvalid=%b rdata=%h rresp=%b rlast=%b required 1 %h %b %b",
                     nm, i, rvalid, rdata, rresp, rlast, ed, er, el);
          end
        end
      end
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
    end
    checks++;
    if ({rvalid, rlast, arready} !== 3'b001) begin
      errors++;
      $display("FAIL %s r_done: rvalid=%b rlast=%b arready=%b required 0 0 1",
               nm, rvalid, rlast, arready);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b110000) begin
      errors++;
      $display("FAIL reset_ctl: aw=%b ar=%b w=%b b=%b r=%b last=%b required 1 1 0 0 0 0",
               awready, arready, wready, bvalid, rvalid, rlast);
    end
    checks++;
    if ({bid, rid, bresp, rresp, rdata} !== '0) begin
      errors++;
      $display("FAIL reset_data: bid=%h rid=%h bresp=%b rresp=%b rdata=%h required all 0",
               bid, rid, bresp, rresp, rdata);
    end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_burst();
    wr_burst(8'h5A, wa(0), 8'd31, 32'd0, 4'hF, -1, 0, 2'b00, "burst_wr");
    rd_burst(8'hA5, wa(0), 8'd31, 32'd0, 32, 1'b0, "burst_rd");
  endtask

  task automatic test_strobe();
    wr_burst(8'h01, wa(100), 8'd0, 32'hAABB_CCDD, 4'hF, -1, 0, 2'b00, "strb_full");
    wr_burst(8'h02, wa(100), 8'd0, 32'h1122_3344, 4'b0101, -1, 0, 2'b00, "strb_part");
    rd_burst(8'h03, wa(100), 8'd0, 32'hAA22_CC44, 1, 1'b0, "strb_rd");
  endtask

  task automatic test_back_pressure();
    rd_burst(8'h10, wa(0), 8'd3, 32'd0, 4, 1'b1, "stall_rd");
    wr_burst(8'h11, wa(110), 8'd1, 32'h77, 4'hF, -1, 5, 2'b00, "bhold_wr");
  endtask

  task automatic test_range();
    wr_burst(8'h20, wa(1022), 8'd3, 32'h50, 4'hF, -1, 0, 2'b10, "oor_wr");
    rd_burst(8'h21, wa(1022), 8'd3, 32'h50, 2, 1'b0, "oor_rd");
    rd_burst(8'h22, wa(0), 8'd0, 32'd0, 1, 1'b0, "oor_word0");
  endtask

  task automatic test_single_and_wlast();
    wr_burst(8'h30, wa(200), 8'd0, 32'hDEAD_BEEF, 4'hF, -1, 0, 2'b00, "single_wr");
    rd_burst(8'h31, wa(200), 8'd0, 32'hDEAD_BEEF, 1, 1'b0, "single_rd");
    wr_burst(8'h32, wa(300), 8'd3, 32'h1000, 4'hF, 1, 0, 2'b10, "early_wlast");
    rd_burst(8'h33, wa(300), 8'd3, 32'h1000, 4, 1'b0, "early_rd");
  endtask

  task automatic test_reset_midburst();
    awid = 8'h40; awaddr = wa(400); awlen = 8'd15; awsize = 3'd2;
    awvalid = 1'b1;
    arid = 8'h41; araddr = wa(0); arlen = 8'd15; arsize = 3'd2;
    arvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; arvalid = 1'b0;
    rready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wvalid = 1'b1; wdata = 32'h2000 + 32'(i); wstrb = 4'hF; wlast = 1'b0;
      @(negedge clk);
    end
    wdata = 32'h2005;
    rstn = 1'b0;
    #1;
    checks++;
    if ({wready, rvalid, bvalid, rlast} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid_out: wready=%b rvalid=%b bvalid=%b rlast=%b required 0 0 0 0",
               wready, rvalid, bvalid, rlast);
    end
    checks++;
    if ({awready, arready} !== 2'b11) begin
      errors++;
      $display("FAIL rst_mid_rdy: awready=%b arready=%b required 1 1",
               awready, arready);
    end
    wvalid = 1'b0; rready = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if ({awready, arready, wready, rvalid} !== 4'b1100) begin
      errors++;
      $display("FAIL rst_release: aw=%b ar=%b w=%b r=%b required 1 1 0 0",
               awready, arready, wready, rvalid);
    end
    rd_burst(8'h42, wa(400), 8'd4, 32'h2000, 5, 1'b0, "rst_partial");
    wr_burst(8'h43, wa(500), 8'd3, 32'h3000, 4'hF, -1, 0, 2'b00, "rst_fresh_wr");
    rd_burst(8'h44, wa(500), 8'd3, 32'h3000, 4, 1'b0, "rst_fresh_rd");
  endtask

  initial begin
    rstn = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01;
    awlock = 1'b0; awcache = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01;
    arlock = 1'b0; arcache = '0; arprot = '0; arvalid = 1'b0;
    rready = 1'b0;
    #2 rstn = 1'b0;
    test_reset();
    test_burst();
    test_strobe();
    test_back_pressure();
    test_range();
    test_single_and_wlast();
    test_reset_midburst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
